perf_stat_counter: RTL and testbench
====================================

// Module: perf_stat_counter
// PURPOSE
//  Run-time statistics block for the single-cycle CPU, upstream of the board LED/display stage.
//  Counts clock cycles and retired conditional branches, taken conditional branches and
//  unconditional jumps, and latches the most recent retired PC.
//  A 3-bit switch select picks one statistic and presents it, registered, to the display path.
//  Counting freezes while the CPU is halted, so the final values can be inspected on the board.
// PARAMETERS
//  CNT_W   32  width of every statistic counter and of disp_value
//  PC_W    32  width of the captured PC; zero-extended to CNT_W when displayed (PC_W <= CNT_W)
// PORTS
//  clk          in   1      system clock; all state updates on the rising edge
//  reset        in   1      synchronous, active-high; clears all state
//  sel          in   3      display select: 001 PC, 010 cycles, 011 cond branches,
//                           100 taken cond branches, 101 uncond jumps; other codes are unused
//  halt         in   1      CPU halted (halt syscall); 1 = freeze all counters and the PC latch
//  instr_valid  in   1      one instruction retires this cycle
//  pc           in   PC_W   PC of the retiring instruction
//  is_cond_br   in   1      retiring instruction is a conditional branch (beq/bne class)
//  br_taken     in   1      its condition was true; ignored unless is_cond_br
//  is_jump      in   1      retiring instruction is an unconditional jump (j/jal/jr class)
//  disp_value   out  CNT_W  selected statistic, registered
//  disp_valid   out  1      1 when sel holds a defined code, registered alongside disp_value
// BEHAVIOUR
//  - Reset: every counter, pc_q, disp_value and disp_valid go to 0 on the first clk edge with
//    reset=1. Reset overrides halt and all event inputs, including in the middle of a run.
//  - "run" = !reset && !halt.
//  - cyc_cnt: +1 on every run cycle. The first cycle with halt=1 is not counted.
//  - cbr_cnt: +1 when run && instr_valid && is_cond_br.
//  - tkn_cnt: +1 when run && instr_valid && is_cond_br && br_taken.
//  - jmp_cnt: +1 when run && instr_valid && is_jump.
//  - pc_q <= pc when run && instr_valid; otherwise it holds.
//  - Event flags are independent. If is_cond_br and is_jump are both set (illegal decode),
//    both counters increment. No error output is raised.
//  - All counters wrap modulo 2^CNT_W; there is no saturation and no overflow flag.
//  - Display latency is one cycle. disp_value at edge N+1 is mux(sel, counters) sampled at
//    edge N, taken from the pre-update register values, not the next-state values.
//  - Undefined sel (000, 110, 111): disp_value <= 0 and disp_valid <= 0.
//  - A sel change is reflected on the next edge. A sel change never disturbs any counter.
//  - When halt deasserts, counting resumes from the held values. Only reset clears them.
//  - The block has no handshake. Event inputs are single-cycle qualified by instr_valid and
//    must be stable around clk.
// STRUCTURE
//  - Shared package perf_pkg holds:
//    - localparams SEL_PC=3'b001, SEL_CYC=3'b010, SEL_CBR=3'b011, SEL_TKN=3'b100, SEL_JMP=3'b101
//    - default CNT_W
//    The LED/display stage imports the same codes.
//  - Sub-module stat_counter #(W) (clk, reset, inc, q) holds one wrapping counter with
//    synchronous clear. It is instantiated four times.
//  - The top level contains the increment qualification, the pc_q register and the
//    registered output mux.
// TESTING
//  1. reset=1 for 2 cycles with all events asserted -> every counter 0, disp_value=0, disp_valid=0.
//  2. Release reset, sel=010, run 10 cycles -> disp_value=9 at the 10th edge, one edge behind
//     the cycle counter.
//  3. Retire 5 cond branches (3 taken) and 2 jumps, then step sel through 011/100/101 ->
//     read 5, 3, 2. Also check that br_taken=1 with is_cond_br=0 does not count.
//  4. Retire pc=32'h0000_0040, then halt=1 for 20 cycles with instr_valid=1 and pc=32'h80 ->
//     sel=001 reads 0x40, and the cycle and event counts are unchanged during halt.
//  5. Preload via force cyc_cnt=32'hFFFF_FFFF, run 1 cycle -> reads 0, with no other side effect.
//  6. sel=111 -> disp_valid=0 and disp_value=0. Assert reset mid-run with halt=1 -> all
//     values clear on the next edge.

Source files
------------

// File: rtl/perf_stat_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perf_pkg
//  Brief    : Display select codes and default widths for the CPU statistics
//             block and the LED/display stage that consumes it.
//  Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_PC_W  = 32;

    localparam logic [2:0] SEL_PC  = 3'b001;
    localparam logic [2:0] SEL_CYC = 3'b010;
    localparam logic [2:0] SEL_CBR = 3'b011;
    localparam logic [2:0] SEL_TKN = 3'b100;
    localparam logic [2:0] SEL_JMP = 3'b101;

endpackage
`default_nettype wire

// File: rtl/perf_stat_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : perf_stat_counter_if
//  Brief    : Retire-event inputs, display select and registered display
//             outputs of the CPU statistics block.
//  Revision : 1.0 - initial release
// ============================================================================
interface perf_stat_counter_if
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PC_W  = DEF_PC_W
);
    logic [2:0]       sel;
    logic             halt;
    logic             instr_valid;
    logic [PC_W-1:0]  pc;
    logic             is_cond_br;
    logic             br_taken;
    logic             is_jump;
    logic [CNT_W-1:0] disp_value;
    logic             disp_valid;

    modport master (
        output sel, halt, instr_valid, pc, is_cond_br, br_taken, is_jump,
        input  disp_value, disp_valid
    );

    modport slave (
        input  sel, halt, instr_valid, pc, is_cond_br, br_taken, is_jump,
        output disp_value, disp_valid
    );
endinterface
`default_nettype wire

// File: rtl/perf_stat_counter_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : stat_counter
//  Brief    : Single wrapping event counter with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module stat_counter
    import perf_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         inc,
    output logic [W-1:0]      q
);
    logic [W-1:0] r_q;

    // Clear has priority over any pending increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/perf_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : perf_stat_counter
//  Brief    : Cycle / branch / jump statistics and last retired PC, with a
//             registered select mux feeding the board display.
//  Revision : 1.0 - initial release
// ============================================================================
module perf_stat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PC_W  = DEF_PC_W
) (
    input  wire logic          clk,
    input  wire logic          reset,
    perf_stat_counter_if.slave bus
);
    logic             w_run;
    logic             w_retire;
    logic             w_inc_cbr;
    logic             w_inc_tkn;
    logic             w_inc_jmp;
    logic [CNT_W-1:0] w_cyc;
    logic [CNT_W-1:0] w_cbr;
    logic [CNT_W-1:0] w_tkn;
    logic [CNT_W-1:0] w_jmp;
    logic [PC_W-1:0]  r_pc_q;
    logic [CNT_W-1:0] w_mux_value;
    logic             w_mux_valid;
    logic [CNT_W-1:0] r_disp_value;
    logic             r_disp_valid;

    // Reset is folded into each counter's clear, so run only needs halt here.
    assign w_run     = !bus.halt;
    assign w_retire  = w_run && bus.instr_valid;
    assign w_inc_cbr = w_retire && bus.is_cond_br;
    assign w_inc_tkn = w_retire && bus.is_cond_br && bus.br_taken;
    assign w_inc_jmp = w_retire && bus.is_jump;

    stat_counter #(.W(CNT_W)) u_cyc_cnt (.clk(clk), .reset(reset), .inc(w_run),     .q(w_cyc));
    stat_counter #(.W(CNT_W)) u_cbr_cnt (.clk(clk), .reset(reset), .inc(w_inc_cbr), .q(w_cbr));
    stat_counter #(.W(CNT_W)) u_tkn_cnt (.clk(clk), .reset(reset), .inc(w_inc_tkn), .q(w_tkn));
    stat_counter #(.W(CNT_W)) u_jmp_cnt (.clk(clk), .reset(reset), .inc(w_inc_jmp), .q(w_jmp));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q <= '0;
        end else if (w_retire) begin
            r_pc_q <= bus.pc;
        end
    end

    always_comb begin
        w_mux_value = '0;
        w_mux_valid = 1'b1;
        case (bus.sel)
            SEL_PC:  w_mux_value = CNT_W'(r_pc_q);
            SEL_CYC: w_mux_value = w_cyc;
            SEL_CBR: w_mux_value = w_cbr;
            SEL_TKN: w_mux_value = w_tkn;
            SEL_JMP: w_mux_value = w_jmp;
            default: w_mux_valid = 1'b0;
        endcase
    end

    // Mux reads current register outputs, so the display trails updates by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_value <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_value <= w_mux_value;
            r_disp_valid <= w_mux_valid;
        end
    end

    assign bus.disp_value = r_disp_value;
    assign bus.disp_valid = r_disp_valid;
endmodule
`default_nettype wire

// File: tb/tb_perf_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perf_stat_counter
//  Brief    : Self-checking bench for perf_stat_counter against a counting model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perf_stat_counter;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    perf_stat_counter_if bus ();

    perf_stat_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain statistic totals plus the expected display.
    logic [31:0] m_cyc = '0;
    logic [31:0] m_cbr = '0;
    logic [31:0] m_tkn = '0;
    logic [31:0] m_jmp = '0;
    logic [31:0] m_pc  = '0;
    logic [31:0] e_val = '0;
    logic        e_vld = 1'b0;
    bit          chk_en = 1'b0;
    bit          preload_pending = 1'b0;

    always @(posedge clk) begin
        if (preload_pending) m_cyc = 32'hFFFF_FFFF;
        if (reset) begin
            m_cyc = '0; m_cbr = '0; m_tkn = '0; m_jmp = '0; m_pc = '0;
            e_val = '0; e_vld = 1'b0;
        end else begin
            e_vld = 1'b1;
            if (bus.sel == SEL_PC)       e_val = m_pc;
            else if (bus.sel == SEL_CYC) e_val = m_cyc;
            else if (bus.sel == SEL_CBR) e_val = m_cbr;
            else if (bus.sel == SEL_TKN) e_val = m_tkn;
            else if (bus.sel == SEL_JMP) e_val = m_jmp;
            else begin e_val = '0; e_vld = 1'b0; end
            if (!bus.halt) begin
                m_cyc = m_cyc + 1;
                if (bus.instr_valid) begin
                    m_pc = bus.pc;
                    if (bus.is_cond_br) m_cbr = m_cbr + 1;
                    if (bus.is_cond_br && bus.br_taken) m_tkn = m_tkn + 1;
                    if (bus.is_jump) m_jmp = m_jmp + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.disp_value !== e_val || bus.disp_valid !== e_vld) begin
                bad++;
                $display("FAIL model_cmp: got value=%h valid=%b, want value=%h valid=%b",
                         bus.disp_value, bus.disp_valid, e_val, e_vld);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] p, input logic cb,
                         input logic bt, input logic j);
        bus.instr_valid = iv; bus.pc = p; bus.is_cond_br = cb;
        bus.br_taken = bt; bus.is_jump = j;
        step();
    endtask

    initial begin
        // Reset with every event asserted
        reset = 1'b1; bus.sel = SEL_CYC; bus.halt = 1'b0;
        bus.instr_valid = 1'b1; bus.pc = 32'h1234; bus.is_cond_br = 1'b1;
        bus.br_taken = 1'b1; bus.is_jump = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_value", bus.disp_value, 32'h0);
        chk("reset_valid", {31'b0, bus.disp_valid}, 32'h0);
        chk("reset_cyc", dut.w_cyc, 32'h0);
        chk("reset_cbr", dut.w_cbr, 32'h0);
        chk("reset_tkn", dut.w_tkn, 32'h0);
        chk("reset_jmp", dut.w_jmp, 32'h0);

        // Ten run cycles: display trails the cycle counter by one edge
        reset = 1'b0;
        bus.instr_valid = 1'b0; bus.is_cond_br = 1'b0; bus.br_taken = 1'b0; bus.is_jump = 1'b0;
        repeat (10) step();
        chk("cyc_after_10", bus.disp_value, 32'd9);
        chk("cyc_valid", {31'b0, bus.disp_valid}, 32'd1);

        // 5 cond branches (3 taken), 2 jumps, one stray br_taken
        repeat (3) drive(1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h1c, 1'b0, 1'b1, 1'b0);
        bus.instr_valid = 1'b0; bus.br_taken = 1'b0;
        bus.sel = SEL_CBR; step(); chk("cbr_count", bus.disp_value, 32'd5);
        bus.sel = SEL_TKN; step(); chk("tkn_count", bus.disp_value, 32'd3);
        bus.sel = SEL_JMP; step(); chk("jmp_count", bus.disp_value, 32'd2);

        // Retire 0x40, then halt with events still firing
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        bus.halt = 1'b1; bus.instr_valid = 1'b1; bus.pc = 32'h80;
        bus.is_cond_br = 1'b1; bus.br_taken = 1'b1; bus.is_jump = 1'b1;
        bus.sel = SEL_PC;
        for (int i = 0; i < 20; i++) begin
            case (i)
                8:  bus.sel = SEL_JMP;
                10: bus.sel = SEL_CBR;
                12: bus.sel = SEL_TKN;
                14: bus.sel = SEL_CYC;
                default: ;
            endcase
            step();
            case (i)
                3:  chk("halt_pc", bus.disp_value, 32'h40);
                9:  chk("halt_jmp", bus.disp_value, 32'd2);
                11: chk("halt_cbr", bus.disp_value, 32'd5);
                13: chk("halt_tkn", bus.disp_value, 32'd3);
                15: chk("halt_cyc", bus.disp_value, 32'd22);
                default: ;
            endcase
        end

        // Wrap of the cycle counter from all-ones
        bus.halt = 1'b0; bus.instr_valid = 1'b0; bus.is_cond_br = 1'b0;
        bus.br_taken = 1'b0; bus.is_jump = 1'b0; bus.sel = SEL_CYC;
        step();
        force dut.u_cyc_cnt.r_q = 32'hFFFF_FFFF;
        preload_pending = 1'b1;
        #1 release dut.u_cyc_cnt.r_q;
        step();
        preload_pending = 1'b0;
        chk("wrap_pre", bus.disp_value, 32'hFFFF_FFFF);
        step();
        chk("wrap_zero", bus.disp_value, 32'h0);
        bus.sel = SEL_CBR; step();
        chk("wrap_cbr_kept", bus.disp_value, 32'd5);

        // Randomized traffic, including undefined selects and occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            bus.sel = 3'($urandom_range(0, 7));
            bus.halt = ($urandom_range(0, 4) == 0);
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.pc = $urandom;
            bus.is_cond_br = 1'($urandom_range(0, 1));
            bus.br_taken = 1'($urandom_range(0, 1));
            bus.is_jump = 1'($urandom_range(0, 1));
            step();
        end

        // Undefined select, then reset during halt
        reset = 1'b0; bus.halt = 1'b0; bus.sel = 3'b111;
        drive(1'b1, 32'hABC, 1'b1, 1'b1, 1'b1);
        chk("sel111_value", bus.disp_value, 32'h0);
        chk("sel111_valid", {31'b0, bus.disp_valid}, 32'h0);
        bus.halt = 1'b1; reset = 1'b1;
        drive(1'b1, 32'hDEF, 1'b1, 1'b1, 1'b1);
        chk("midrst_cyc", dut.w_cyc, 32'h0);
        chk("midrst_cbr", dut.w_cbr, 32'h0);
        chk("midrst_jmp", dut.w_jmp, 32'h0);
        reset = 1'b0; bus.sel = SEL_CYC; step();
        chk("midrst_disp_cyc", bus.disp_value, 32'h0);
        bus.sel = SEL_PC; step();
        chk("midrst_disp_pc", bus.disp_value, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
